// File: rtl/rr_cfg_pkg.sv
// Shared definitions for the record/replay configuration bus.
//   - AXI-Lite response codes
//   - width of the BAR1 high window decoded by the responder
//   - 32-bit register word type and byte-strobe merge helper
package rr_cfg_pkg;

  localparam logic [1:0] RR_AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] RR_AXIL_RESP_SLVERR = 2'b10;

  localparam int RR_CFG_WINDOW_BITS = 20;

  typedef logic [31:0] rr_cfg_word_t;

  // Merge new_w into old_w, byte lane b taken from new_w when strb[b] is set.
  function automatic rr_cfg_word_t rr_apply_strb(input rr_cfg_word_t old_w,
                                                 input rr_cfg_word_t new_w,
                                                 input logic [3:0]   strb);
    rr_cfg_word_t res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_axi_lite_bus.sv
// AXI-Lite bus bundle (32-bit addr/data, 4-bit strobe, 2-bit response).
// The 'master' modport is the responder end: it receives AW/W/AR and
// drives the ready signals plus the B and R channels.
interface rr_axi_lite_bus_t;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/rr_cfg_axil_responder.sv
// AXI-Lite responder for the record/replay configuration window.
// Exposes NUM_REGS 32-bit registers at byte offset 4*i. Registers with
// RO_MASK[i]=1 return status_regs[i] and reject writes; the rest are
// writable control registers driven on cfg_regs.
// Ports:
//   clk, rstn     - clock, async active-low reset
//   cfg_bus       - AXI-Lite responder end
//   cfg_regs      - current RW register values (RO entries read 0)
//   cfg_wr_pulse  - one-cycle strobe per register after a committed write
//   status_regs   - read-back values for RO registers
module rr_cfg_axil_responder
  import rr_cfg_pkg::*;
#(
  parameter int                    NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK  = '0
) (
  input  logic                          clk,
  input  logic                          rstn,
  rr_axi_lite_bus_t.master              cfg_bus,
  output logic [NUM_REGS-1:0][31:0]     cfg_regs,
  output logic [NUM_REGS-1:0]           cfg_wr_pulse,
  input  logic [NUM_REGS-1:0][31:0]     status_regs
);

  localparam int                    IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int                    WB   = RR_CFG_WINDOW_BITS;
  localparam logic [WB:0]           SPAN = (WB+1)'(4 * NUM_REGS);

  rr_cfg_word_t [NUM_REGS-1:0] regs_q;

  // write path state
  logic          aw_full, w_full;
  logic [WB-1:0] aw_off_q;
  rr_cfg_word_t  wdata_q;
  logic [3:0]    wstrb_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;

  // read path state
  logic          rvalid_q;
  logic [1:0]    rresp_q;
  rr_cfg_word_t  rdata_q;

  logic aw_hs, w_hs, ar_hs, commit;

  assign cfg_bus.awready = !aw_full && !bvalid_q;
  assign cfg_bus.wready  = !w_full  && !bvalid_q;
  assign cfg_bus.bvalid  = bvalid_q;
  assign cfg_bus.bresp   = bresp_q;
  assign cfg_bus.arready = !rvalid_q;
  assign cfg_bus.rvalid  = rvalid_q;
  assign cfg_bus.rresp   = rresp_q;
  assign cfg_bus.rdata   = rdata_q;

  assign aw_hs  = cfg_bus.awvalid && cfg_bus.awready;
  assign w_hs   = cfg_bus.wvalid  && cfg_bus.wready;
  assign ar_hs  = cfg_bus.arvalid && cfg_bus.arready;
  assign commit = (aw_full || aw_hs) && (w_full || w_hs);

  // Commit operands come from the hold registers if already captured,
  // otherwise straight off the bus in the handshake cycle.
  logic [WB-1:0]   wr_off;
  rr_cfg_word_t    wr_data;
  logic [3:0]      wr_strb;
  logic            wr_in, wr_ok;
  logic [IDXW-1:0] wr_idx;

  assign wr_off  = aw_full ? aw_off_q : cfg_bus.awaddr[WB-1:0];
  assign wr_data = w_full  ? wdata_q  : cfg_bus.wdata;
  assign wr_strb = w_full  ? wstrb_q  : cfg_bus.wstrb;
  assign wr_in   = {1'b0, wr_off} < SPAN;
  assign wr_idx  = wr_off[2 +: IDXW];
  assign wr_ok   = wr_in && !RO_MASK[wr_idx];

  logic [WB-1:0]   rd_off;
  logic            rd_in;
  logic [IDXW-1:0] rd_idx;

  assign rd_off = cfg_bus.araddr[WB-1:0];
  assign rd_in  = {1'b0, rd_off} < SPAN;
  assign rd_idx = rd_off[2 +: IDXW];

  // Address bits outside the window and the byte offset are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cfg_bus.awaddr[31:WB], cfg_bus.araddr[31:WB],
                              wr_off[1:0], rd_off[1:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regs_q       <= '0;
      cfg_wr_pulse <= '0;
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_off_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RR_AXIL_RESP_OKAY;
    end else begin
      cfg_wr_pulse <= '0;
      if (commit) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RR_AXIL_RESP_OKAY : RR_AXIL_RESP_SLVERR;
        if (wr_ok) begin
          regs_q[wr_idx]       <= rr_apply_strb(regs_q[wr_idx], wr_data, wr_strb);
          cfg_wr_pulse[wr_idx] <= 1'b1;
        end
      end else begin
        if (aw_hs) begin
          aw_full  <= 1'b1;
          aw_off_q <= cfg_bus.awaddr[WB-1:0];
        end
        if (w_hs) begin
          w_full  <= 1'b1;
          wdata_q <= cfg_bus.wdata;
          wstrb_q <= cfg_bus.wstrb;
        end
        // readies are low while bvalid is set, so no commit can overlap this
        if (bvalid_q && cfg_bus.bready) bvalid_q <= 1'b0;
      end
    end
  end

  // Read data samples regs_q before any same-edge commit lands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RR_AXIL_RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      if (!rd_in) begin
        rdata_q <= '0;
        rresp_q <= RR_AXIL_RESP_SLVERR;
      end else if (RO_MASK[rd_idx]) begin
        rdata_q <= status_regs[rd_idx];
        rresp_q <= RR_AXIL_RESP_OKAY;
      end else begin
        rdata_q <= regs_q[rd_idx];
        rresp_q <= RR_AXIL_RESP_OKAY;
      end
    end else if (rvalid_q && cfg_bus.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    if (RO_MASK[i]) begin : g_ro
      assign cfg_regs[i] = '0;
    end else begin : g_rw
      assign cfg_regs[i] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_rr_cfg_axil_responder.sv
module tb_rr_cfg_axil_responder;
  localparam int NR = 16;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic clk, rstn;
  rr_axi_lite_bus_t bus();
  logic [NR-1:0][31:0] cfg_regs;
  logic [NR-1:0]       cfg_wr_pulse;
  logic [NR-1:0][31:0] status_regs;
  logic [NR-1:0][31:0] exp_regs;

  rr_cfg_axil_responder #(.NUM_REGS(NR), .RO_MASK(16'h0008)) dut (
    .clk(clk), .rstn(rstn), .cfg_bus(bus),
    .cfg_regs(cfg_regs), .cfg_wr_pulse(cfg_wr_pulse), .status_regs(status_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [31:0] d; logic [1:0] r; } rexp_t;
  logic [1:0] b_q[$];
  rexp_t      r_q[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // scoreboard monitors: a negedge with valid&&ready precedes a handshake edge
  logic [1:0] b_exp;
  rexp_t      r_exp;
  always @(negedge clk) begin
    if (rstn && bus.bvalid && bus.bready) begin
      if (b_q.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: got bresp %0h want none", bus.bresp);
      end else begin
        b_exp = b_q.pop_front();
        chk("bresp", 512'(bus.bresp), 512'(b_exp));
      end
    end
    if (rstn && bus.rvalid && bus.rready) begin
      if (r_q.size() == 0) begin
        total++; bad++;
        $display("FAIL r_unexpected: got rdata %0h want none", bus.rdata);
      end else begin
        r_exp = r_q.pop_front();
        chk("rdata", 512'(bus.rdata), 512'(r_exp.d));
        chk("rresp", 512'(bus.rresp), 512'(r_exp.r));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_aw(input logic [31:0] a);
    bus.awaddr = a; bus.awvalid = 1'b1;
  endtask
  task automatic set_w(input logic [31:0] d, input logic [3:0] s);
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
  endtask
  task automatic set_ar(input logic [31:0] a);
    bus.araddr = a; bus.arvalid = 1'b1;
  endtask

  // Drive pending valids until each handshakes; returns #1 after the last edge.
  task automatic wait_hs();
    int n;
    logic a, w, r;
    n = 0;
    while ((bus.awvalid || bus.wvalid || bus.arvalid) && n < 40) begin
      @(negedge clk);
      a = bus.awvalid && bus.awready;
      w = bus.wvalid  && bus.wready;
      r = bus.arvalid && bus.arready;
      @(posedge clk); #1;
      if (a) bus.awvalid = 1'b0;
      if (w) bus.wvalid  = 1'b0;
      if (r) bus.arvalid = 1'b0;
      n++;
    end
    if (bus.awvalid || bus.wvalid || bus.arvalid) begin
      total++; bad++;
      $display("FAIL hs_timeout: got pending %b want 000", {bus.awvalid, bus.wvalid, bus.arvalid});
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    end
  endtask

  initial begin
    rstn = 1'b0;
    bus.awvalid = 0; bus.awaddr = '0;
    bus.wvalid = 0;  bus.wdata = '0; bus.wstrb = '0;
    bus.arvalid = 0; bus.araddr = '0;
    bus.bready = 1;  bus.rready = 1;
    for (int i = 0; i < NR; i++) status_regs[i] = 32'h5555_0000 + i;
    status_regs[3] = 32'hCAFE_F00D;
    exp_regs = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    step();

    // reset state
    chk("rst_regs", cfg_regs, exp_regs);
    chk("rst_pulse", 512'(cfg_wr_pulse), 512'(0));
    chk("rst_flags", 512'({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}), 512'(5'b00111));
    chk("rst_rdata", 512'(bus.rdata), 512'(0));

    // aligned write, AW+W together
    set_aw(32'h8); set_w(32'hA5A5_1234, 4'hF); b_q.push_back(OK);
    wait_hs();
    exp_regs[2] = 32'hA5A5_1234;
    chk("w1_regs", cfg_regs, exp_regs);
    chk("w1_pulse", 512'(cfg_wr_pulse), 512'(16'h0004));
    chk("w1_bvalid", 512'(bus.bvalid), 512'(1));
    step();
    chk("w1_pulse_off", 512'(cfg_wr_pulse), 512'(0));
    set_ar(32'h8); r_q.push_back('{32'hA5A5_1234, OK});
    wait_hs();
    chk("r1_rvalid", 512'(bus.rvalid), 512'(1));
    step();
    // bits above the 1MB window are ignored
    set_ar(32'h8010_0008); r_q.push_back('{32'hA5A5_1234, OK});
    wait_hs(); step();

    // W three cycles before AW, partial strobe
    set_w(32'hFFFF_FFFF, 4'h5); b_q.push_back(OK);
    wait_hs();
    chk("w2_wready_lo", 512'(bus.wready), 512'(0));
    step(); step();
    chk("w2_wready_hold", 512'(bus.wready), 512'(0));
    chk("w2_no_commit", cfg_regs, exp_regs);
    set_aw(32'h4);
    wait_hs();
    exp_regs[1] = 32'h00FF_00FF;
    chk("w2_regs", cfg_regs, exp_regs);
    chk("w2_pulse", 512'(cfg_wr_pulse), 512'(16'h0002));
    step();

    // last register, addr[1:0] ignored, upper bytes only
    set_aw(32'h3E); set_w(32'h1234_5678, 4'hC); b_q.push_back(OK);
    wait_hs();
    exp_regs[15] = 32'h1234_0000;
    chk("w15_regs", cfg_regs, exp_regs);
    chk("w15_pulse", 512'(cfg_wr_pulse), 512'(16'h8000));
    step();

    // out of range
    set_aw(32'h40); set_w(32'hDEAD_BEEF, 4'hF); b_q.push_back(ERR);
    wait_hs();
    chk("oor_pulse", 512'(cfg_wr_pulse), 512'(0));
    chk("oor_regs", cfg_regs, exp_regs);
    step();
    set_ar(32'h40); r_q.push_back('{32'h0, ERR});
    wait_hs(); step();

    // read-only register
    set_ar(32'hC); r_q.push_back('{32'hCAFE_F00D, OK});
    wait_hs(); step();
    set_aw(32'hC); set_w(32'h0BAD_0BAD, 4'hF); b_q.push_back(ERR);
    wait_hs();
    chk("ro_pulse", 512'(cfg_wr_pulse), 512'(0));
    chk("ro_regs", cfg_regs, exp_regs);
    step();

    // backpressure on B, read in the commit cycle sees the old value
    bus.bready = 1'b0;
    set_aw(32'h0); set_w(32'h1111_2222, 4'hF); set_ar(32'h0);
    b_q.push_back(OK); r_q.push_back('{32'h0, OK});
    wait_hs();
    exp_regs[0] = 32'h1111_2222;
    chk("bp_regs", cfg_regs, exp_regs);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 512'({bus.bvalid, bus.awready, bus.wready}), 512'(3'b100));
      step();
    end
    set_aw(32'h0); set_w(32'h0000_0033, 4'h1); b_q.push_back(OK);
    step(); step();
    chk("bp_aw_held", 512'(bus.awready), 512'(0));
    chk("bp_regs_held", cfg_regs, exp_regs);
    bus.bready = 1'b1;
    wait_hs();
    exp_regs[0] = 32'h1111_2233;
    chk("bp2_regs", cfg_regs, exp_regs);
    chk("bp2_pulse", 512'(cfg_wr_pulse), 512'(16'h0001));
    step();

    // async reset with held AW and pending R
    set_aw(32'h4); wait_hs();
    bus.rready = 1'b0;
    set_ar(32'h8); wait_hs();
    chk("pre_rst_rvalid", 512'(bus.rvalid), 512'(1));
    #2 rstn = 1'b0;
    #1;
    exp_regs = '0;
    chk("arst_flags", 512'({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}), 512'(5'b00111));
    chk("arst_regs", cfg_regs, exp_regs);
    chk("arst_rdata", 512'(bus.rdata), 512'(0));
    @(negedge clk) rstn = 1'b1;
    bus.rready = 1'b1;
    step();
    set_w(32'h7777_7777, 4'hF);
    wait_hs();
    step(); step();
    chk("post_rst_no_commit", cfg_regs, exp_regs);
    chk("post_rst_flags", 512'({cfg_wr_pulse, bus.bvalid, bus.wready}), 512'({16'h0, 2'b00}));
    set_aw(32'h0); b_q.push_back(OK);
    wait_hs();
    exp_regs[0] = 32'h7777_7777;
    chk("post_rst_regs", cfg_regs, exp_regs);
    chk("post_rst_pulse", 512'(cfg_wr_pulse), 512'(16'h0001));

    for (int i = 0; i < 20 && (b_q.size() != 0 || r_q.size() != 0); i++) step();
    if (b_q.size() != 0 || r_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", b_q.size(), r_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
